// File: rtl/rms_mean_square.sv
// rtl/rms_mean_square.sv - windowed mean-square feeder for the RMS square-root stage
//
// Squares each valid signed sample, sums a window of 2**LOG2_N squares and
// presents the window mean as rms_radicand with a one-cycle radicand_valid.
// Windows run back to back with no dropped samples.
//
// Optional feature macro: RMS_MS_PEAK_EN (per-window max |sample| on peak_abs).
//
// Ports:
//   clk            - system clock, rising edge
//   rst            - synchronous, active-high reset
//   sample_in      - signed two's-complement sample
//   sample_valid   - sample_in is consumed this cycle
//   win_clear      - synchronous abort of the partial window
//   rms_radicand   - mean of squares of the last complete window
//   radicand_valid - one-cycle pulse when rms_radicand updates
//   sample_count   - squares accumulated in the current window
//   peak_abs       - max |sample| of the last window (0 when feature disabled)

module rms_mean_square #(
    parameter int SAMPLE_W = 8,
    parameter int LOG2_N   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                win_clear,
    output logic [15:0]         rms_radicand,
    output logic                radicand_valid,
    output logic [LOG2_N-1:0]   sample_count,
    output logic [SAMPLE_W-1:0] peak_abs
);

    localparam int SQ_W  = 2 * SAMPLE_W;
    // Wide enough for 2**LOG2_N worst-case squares, so the sum never wraps.
    localparam int ACC_W = SQ_W + LOG2_N;
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    logic signed [SQ_W-1:0] prod;
    logic [SQ_W-1:0]        sq_r;
    logic                   sq_v;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       acc_sum;
    logic [LOG2_N-1:0]      count;
    logic                   win_end;

    assign prod    = $signed(sample_in) * $signed(sample_in);
    assign acc_sum = acc + ACC_W'(sq_r);
    // A clear on the closing cycle suppresses the window result entirely.
    assign win_end = sq_v && (count == CNT_LAST) && !win_clear;

    // Stage 1: square register
    always_ff @(posedge clk) begin
        if (rst || win_clear) begin
            sq_r <= '0;
            sq_v <= 1'b0;
        end else begin
            sq_v <= sample_valid;
            if (sample_valid) begin
                sq_r <= $unsigned(prod);
            end
        end
    end

    // Stage 2: accumulate and publish the window mean
    always_ff @(posedge clk) begin
        if (rst) begin
            acc            <= '0;
            count          <= '0;
            rms_radicand   <= '0;
            radicand_valid <= 1'b0;
        end else begin
            radicand_valid <= 1'b0;
            if (win_clear) begin
                acc   <= '0;
                count <= '0;
            end else if (win_end) begin
                rms_radicand   <= 16'(acc_sum >> LOG2_N);
                radicand_valid <= 1'b1;
                acc            <= '0;
                count          <= '0;
            end else if (sq_v) begin
                acc   <= acc_sum;
                count <= count + 1'b1;
            end
        end
    end

    assign sample_count = count;

`ifdef RMS_MS_PEAK_EN
    localparam logic [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

    logic [SAMPLE_W-1:0] abs_in;
    logic [SAMPLE_W-1:0] peak_tr;
    logic [SAMPLE_W-1:0] peak_q;

    // The most negative code has no positive twin; saturate it.
    always_comb begin
        abs_in = sample_in;
        if (sample_in == S_MIN) begin
            abs_in = S_MAX;
        end else if (sample_in[SAMPLE_W-1]) begin
            abs_in = -sample_in;
        end
    end

    // Tracker runs in the square stage, one cycle ahead of the accumulator,
    // so at window end it already holds the whole window and the sample
    // arriving on that same edge seeds the next window.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_tr <= '0;
            peak_q  <= '0;
        end else if (win_clear) begin
            peak_tr <= '0;
        end else if (win_end) begin
            peak_q  <= peak_tr;
            peak_tr <= sample_valid ? abs_in : '0;
        end else if (sample_valid && (abs_in > peak_tr)) begin
            peak_tr <= abs_in;
        end
    end

    assign peak_abs = peak_q;
`else
    assign peak_abs = '0;
`endif

endmodule
